// File: rtl/if_stage.sv
// if_stage: PC register, IM addressing and IF/ID pipeline register with stall/flush/redirect.
module if_stage #(
    parameter int              IMW      = 4,
    parameter int              DW       = 32,
    parameter int              IW       = 32,
    parameter logic [DW-1:0]   RESET_PC = '0,
    parameter logic [IW-1:0]   NOP      = 32'h00000013,
    parameter int              CW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           redirect_valid,
    input  logic [DW-1:0]  redirect_pc,
    output logic [IMW-1:0] im_addr,
    input  logic [IW-1:0]  im_data,
    output logic [DW-1:0]  pc,
    output logic [IW-1:0]  if_id_instr,
    output logic [DW-1:0]  if_id_pc,
    output logic           if_id_valid,
    output logic [CW-1:0]  fetch_count
);
    logic          bubble;
    logic          fetch;
    logic [DW-1:0] pc_next;

    assign im_addr = pc[IMW+1:2];
    // Stall alone holds IF/ID; stall with flush still squashes it.
    assign bubble  = redirect_valid || flush;
    assign fetch   = !redirect_valid && !stall && !flush;
    assign pc_next = redirect_valid ? {redirect_pc[DW-1:2], 2'b00} : stall ? pc : pc + DW'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc          <= pc_next;
            if_id_instr <= bubble ? NOP : stall ? if_id_instr : im_data;
            if_id_valid <= bubble ? 1'b0 : stall ? if_id_valid : 1'b1;
            if_id_pc    <= redirect_valid || (flush && !stall) ? '0 : stall ? if_id_pc : pc;
            fetch_count <= fetch ? fetch_count + CW'(1) : fetch_count;
        end
    end
endmodule
